multicycle_ctrl_irq: RTL and testbench
======================================

// Module: multicycle_ctrl_irq
// PURPOSE
//  Multicycle MIPS control FSM with a parametrised interrupt front end: N_IRQ maskable edge-triggered
//  sources, an edge-triggered NMI, fixed priority, per-source ack and an illegal-instruction trap.
//  Drives the multicycle datapath mux/enable controls and supplies the vector source to the PC-vector mux.
// PARAMETERS
//  N_IRQ   4  number of maskable interrupt lines (1..16)
//  SRC_W   $clog2(N_IRQ+2)  localparam; width of int_src
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  op           in   6      IR[31:26]
//  funct        in   6      IR[5:0]
//  irq          in   N_IRQ  maskable sources, rising edge sets pending
//  irq_mask     in   N_IRQ  1 = source enabled
//  intd         in   1      1 = all maskable sources blocked (NMI unaffected)
//  nmi          in   1      non-maskable, rising edge sets pending
//  pc_write, ir_write, lor_d, mem_write, reg_write, alu_src_a, is_branch  out 1  datapath enables/selects
//  mem_to_reg, reg_dst, alu_src_b, pc_source, alu_control  out 2  datapath selects
//  is_interrupted  out  1      high in INT_SAVE and INT_VECTOR
//  int_src      out  SRC_W  0 = NMI, i+1 = irq[i], N_IRQ+1 = illegal trap; held until next take
//  irq_ack      out  N_IRQ  one-hot, one-cycle pulse in INT_VECTOR for the taken maskable source
// BEHAVIOUR
//  - Reset (async, any state): state=PREFETCH; all pending cleared; edge registers set to all-ones
//    (a line already high at release needs a new rising edge); int_src=0; every output 0.
//  - Outputs are Moore, decoded from state (plus funct for alu_control); no latches, every output assigned in every state.
//  - Pending: set on clock where line=1 and previous sample=0. Cleared by the ack cycle of that source;
//    set wins over clear in the same cycle. Masked/intd-blocked pending bits stay pending.
//  - Selection in PREFETCH: NMI > irq[0] > irq[1] > ... ; eligible maskable = pending & irq_mask & ~intd.
//  - States / transitions (one cycle each):
//    PREFETCH: take -> INT_SAVE (latch int_src); else -> FETCH.
//    FETCH: ir_write=1 pc_write=1 alu_src_b=01 alu_control=ADD -> DECODE.
//    DECODE: alu_src_b=11 alu_control=ADD; lw/sw->MEM_ADDR, R-type->EXECUTE, beq->BRANCH, j->JUMP,
//      andi/ori/xori/lui->IMM_EXEC; any other op, or R-type with funct not in {ADD,SUB,AND,XOR} -> ILLEGAL.
//    MEM_ADDR: alu_src_a=1 alu_src_b=10 ADD; lw->MEM_READ, sw->MEM_WRITE.
//    MEM_READ: lor_d=1 -> MEM_WB.  MEM_WB: reg_dst=00 mem_to_reg=01 reg_write=1 -> PREFETCH.
//    MEM_WRITE: lor_d=1 mem_write=1 -> PREFETCH.
//    EXECUTE: alu_src_a=1 alu_src_b=00 alu_control=funct decode -> ALU_WB.
//    ALU_WB: reg_dst=01 mem_to_reg=00 reg_write=1 -> PREFETCH.
//    BRANCH: alu_src_a=1 alu_src_b=00 SUB is_branch=1 pc_source=01 -> PREFETCH.
//    JUMP: pc_write=1 pc_source=10 -> PREFETCH.
//    IMM_EXEC: alu_src_a=1 alu_src_b=10 funct decode -> IMM_WB (=ALU_WB outputs) -> PREFETCH.
//    ILLEGAL: int_src=N_IRQ+1 -> INT_SAVE.
//    INT_SAVE: is_interrupted=1 reg_dst=10 mem_to_reg=10 reg_write=1 (PC to $31) -> INT_VECTOR.
//    INT_VECTOR: is_interrupted=1 pc_write=1 pc_source=11 irq_ack pulse (none for NMI/trap; NMI pending
//      cleared here) -> FETCH (no re-check; guarantees one instruction of progress).
//  - alu_control: ADD=10 SUB=11 AND=00 XOR=01; never X/Z; illegal funct routes to ILLEGAL.
//  - Latency: irq edge at cycle k with FSM entering PREFETCH at k+1 -> INT_SAVE at k+2, vector fetch at k+4.
//  - Interrupts are sampled only in PREFETCH; an edge during an instruction waits for its completion.
// STRUCTURE
//  - Package ctrl_pkg: state encoding, opcode/funct constants, alu_control/reg_dst/mem_to_reg/pc_source encodings.
//  - Sub-module irq_pending_unit: edge detect, pending regs, mask/intd gating, priority encode, ack clear.
//  - Top: state register, next-state logic, output decode.
// TESTING
//  1 Reset mid-MEM_WRITE: rst_n low -> mem_write=0 immediately, next state PREFETCH, then FETCH.
//  2 lw sequence op=100011: states PREFETCH,FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB; reg_write=1 only in MEM_WB.
//  3 irq=0011, mask=1111, intd=0 same edge: int_src=1, irq_ack=0001; irq[1] remains pending, taken next PREFETCH, int_src=2.
//  4 irq[2] edge with mask[2]=0: no take; set mask[2]=1 -> taken at next PREFETCH, irq_ack=0100.
//  5 intd=1, nmi edge plus irq[0] edge: NMI taken int_src=0, irq_ack=0; irq[0] held pending until intd=0.
//  6 op=111111 -> DECODE->ILLEGAL->INT_SAVE, int_src=N_IRQ+1; R-type funct=100111 same result; alu_control never X.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and the Moore output decode for the multicycle control FSM.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_PREFETCH   = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_MEM_READ   = 4'd4,
        S_MEM_WB     = 4'd5,
        S_MEM_WRITE  = 4'd6,
        S_EXECUTE    = 4'd7,
        S_ALU_WB     = 4'd8,
        S_BRANCH     = 4'd9,
        S_JUMP       = 4'd10,
        S_IMM_EXEC   = 4'd11,
        S_IMM_WB     = 4'd12,
        S_ILLEGAL    = 4'd13,
        S_INT_SAVE   = 4'd14,
        S_INT_VECTOR = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;
    localparam logic [1:0] PCS_VEC  = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       lor_d;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       is_branch;
        logic       is_interrupted;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_control;
    } ctrl_t;

    // R-type functions the ALU implements; anything else traps.
    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) ||
               (funct == FN_AND) || (funct == FN_XOR);
    endfunction

    // Map funct to ALU op; unknown codes fall back to ADD so the output is never X.
    function automatic logic [1:0] alu_from_funct(input logic [5:0] funct);
        logic [1:0] a;
        case (funct)
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_XOR:  a = ALU_XOR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore decode of datapath controls for a given state.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write    = 1'b1;
                c.pc_write    = 1'b1;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b   = SRCB_BOFF;
                c.alu_control = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEM_READ: c.lor_d = 1'b1;
            S_MEM_WB: begin
                c.reg_dst    = RD_RT;
                c.mem_to_reg = M2R_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.lor_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE, S_IMM_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = (s == S_EXECUTE) ? SRCB_REG : SRCB_IMM;
                c.alu_control = alu_from_funct(funct);
            end
            S_ALU_WB, S_IMM_WB: begin
                c.reg_dst    = RD_RD;
                c.mem_to_reg = M2R_ALU;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_REG;
                c.alu_control = ALU_SUB;
                c.is_branch   = 1'b1;
                c.pc_source   = PCS_BR;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            S_INT_SAVE: begin
                c.is_interrupted = 1'b1;
                c.reg_dst        = RD_RA;
                c.mem_to_reg     = M2R_PC;
                c.reg_write      = 1'b1;
            end
            S_INT_VECTOR: begin
                c.is_interrupted = 1'b1;
                c.pc_write       = 1'b1;
                c.pc_source      = PCS_VEC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_irq_if.sv
// Instruction/interrupt inputs and datapath control outputs of the control unit.
interface multicycle_ctrl_irq_if #(
    parameter int unsigned N_IRQ = 4
);
    localparam int unsigned SRC_W = $clog2(N_IRQ + 2);

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_mask;
    logic             intd;
    logic             nmi;

    logic             pc_write;
    logic             ir_write;
    logic             lor_d;
    logic             mem_write;
    logic             reg_write;
    logic             alu_src_a;
    logic             is_branch;
    logic [1:0]       mem_to_reg;
    logic [1:0]       reg_dst;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [1:0]       alu_control;
    logic             is_interrupted;
    logic [SRC_W-1:0] int_src;
    logic [N_IRQ-1:0] irq_ack;

    modport master (
        output op, funct, irq, irq_mask, intd, nmi,
        input  pc_write, ir_write, lor_d, mem_write, reg_write, alu_src_a, is_branch,
               mem_to_reg, reg_dst, alu_src_b, pc_source, alu_control,
               is_interrupted, int_src, irq_ack
    );

    modport slave (
        input  op, funct, irq, irq_mask, intd, nmi,
        output pc_write, ir_write, lor_d, mem_write, reg_write, alu_src_a, is_branch,
               mem_to_reg, reg_dst, alu_src_b, pc_source, alu_control,
               is_interrupted, int_src, irq_ack
    );
endinterface

// File: rtl/multicycle_ctrl_irq_pending.sv
// Interrupt front end: edge capture, pending bits, gating, fixed-priority select, ack clear.
module irq_pending_unit #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned SRC_W = $clog2(N_IRQ + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             intd,
    input  logic             nmi,
    input  logic             ack_en,
    input  logic [SRC_W-1:0] ack_src,
    output logic             take_c,
    output logic [SRC_W-1:0] src_c
);

    logic [N_IRQ-1:0] irq_prev;
    logic             nmi_prev;
    logic [N_IRQ-1:0] irq_pend;
    logic             nmi_pend;
    logic [N_IRQ-1:0] irq_clr;
    logic             nmi_clr;
    logic [N_IRQ-1:0] eligible;

    // Decode which pending bit the current vector cycle acknowledges.
    always_comb begin
        irq_clr = '0;
        nmi_clr = 1'b0;
        if (ack_en) begin
            nmi_clr = (ack_src == '0);
            for (int i = 0; i < int'(N_IRQ); i++) begin
                irq_clr[i] = (ack_src == SRC_W'(i + 1));
            end
        end
    end

    // Edge samplers start high so lines already asserted at reset release are ignored; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '1;
            nmi_prev <= 1'b1;
            irq_pend <= '0;
            nmi_pend <= 1'b0;
        end else begin
            irq_prev <= irq;
            nmi_prev <= nmi;
            irq_pend <= (irq_pend & ~irq_clr) | (irq & ~irq_prev);
            nmi_pend <= (nmi_pend & ~nmi_clr) | (nmi & ~nmi_prev);
        end
    end

    assign eligible = irq_pend & irq_mask & {N_IRQ{~intd}};

    // Fixed priority: NMI first, then lowest-numbered eligible line.
    always_comb begin
        take_c = 1'b0;
        src_c  = '0;
        if (nmi_pend) begin
            take_c = 1'b1;
        end else begin
            for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    take_c = 1'b1;
                    src_c  = SRC_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl_irq.sv
// Multicycle MIPS control FSM with maskable IRQs, NMI and illegal-instruction trap.
module multicycle_ctrl_irq
    import ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ = 4
) (
    input logic                clk,
    input logic                rst_n,
    multicycle_ctrl_irq_if.slave bus
);

    localparam int unsigned SRC_W = $clog2(N_IRQ + 2);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [SRC_W-1:0] int_src_q, int_src_d;
    logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
    logic             take_c;
    logic [SRC_W-1:0] src_c;

    irq_pending_unit #(
        .N_IRQ (N_IRQ),
        .SRC_W (SRC_W)
    ) u_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (bus.irq),
        .irq_mask (bus.irq_mask),
        .intd     (bus.intd),
        .nmi      (bus.nmi),
        .ack_en   (state_q == S_INT_VECTOR),
        .ack_src  (int_src_q),
        .take_c   (take_c),
        .src_c    (src_c)
    );

    // Next state, latched source and next registered outputs.
    always_comb begin
        state_d   = state_q;
        int_src_d = int_src_q;
        irq_ack_d = '0;
        case (state_q)
            S_PREFETCH: begin
                if (take_c) begin
                    state_d   = S_INT_SAVE;
                    int_src_d = src_c;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = funct_legal(bus.funct) ? S_EXECUTE : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_IMM_EXEC;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_PREFETCH;
            S_MEM_WRITE: state_d = S_PREFETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_PREFETCH;
            S_BRANCH:    state_d = S_PREFETCH;
            S_JUMP:      state_d = S_PREFETCH;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_PREFETCH;
            S_ILLEGAL: begin
                state_d   = S_INT_SAVE;
                int_src_d = SRC_W'(N_IRQ + 1);
            end
            S_INT_SAVE:   state_d = S_INT_VECTOR;
            S_INT_VECTOR: state_d = S_FETCH;
            default:      state_d = S_PREFETCH;
        endcase

        if (state_d == S_INT_VECTOR) begin
            for (int i = 0; i < int'(N_IRQ); i++) begin
                irq_ack_d[i] = (int_src_q == SRC_W'(i + 1));
            end
        end

        ctrl_d = decode_ctrl(state_d, bus.funct);
    end

    // State register; outputs are registered alongside so they track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PREFETCH;
            ctrl_q    <= '0;
            int_src_q <= '0;
            irq_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            int_src_q <= int_src_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign bus.pc_write       = ctrl_q.pc_write;
    assign bus.ir_write       = ctrl_q.ir_write;
    assign bus.lor_d          = ctrl_q.lor_d;
    assign bus.mem_write      = ctrl_q.mem_write;
    assign bus.reg_write      = ctrl_q.reg_write;
    assign bus.alu_src_a      = ctrl_q.alu_src_a;
    assign bus.is_branch      = ctrl_q.is_branch;
    assign bus.is_interrupted = ctrl_q.is_interrupted;
    assign bus.mem_to_reg     = ctrl_q.mem_to_reg;
    assign bus.reg_dst        = ctrl_q.reg_dst;
    assign bus.alu_src_b      = ctrl_q.alu_src_b;
    assign bus.pc_source      = ctrl_q.pc_source;
    assign bus.alu_control    = ctrl_q.alu_control;
    assign bus.int_src        = int_src_q;
    assign bus.irq_ack        = irq_ack_q;

endmodule

// File: tb/tb_multicycle_ctrl_irq.sv
// Directed bench for multicycle_ctrl_irq: state walks, interrupt priority, masking, trap.
module tb_multicycle_ctrl_irq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_irq_if #(.N_IRQ(4)) bus ();

    multicycle_ctrl_irq #(.N_IRQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pc_write,ir_write,lor_d,mem_write,reg_write,alu_src_a,is_branch,is_interrupted,
    //  mem_to_reg,reg_dst,alu_src_b,pc_source,alu_control}
    localparam logic [17:0] E_PRE  = 18'b00000000_00_00_00_00_00;
    localparam logic [17:0] E_F    = 18'b11000000_00_00_01_00_10;
    localparam logic [17:0] E_D    = 18'b00000000_00_00_11_00_10;
    localparam logic [17:0] E_MA   = 18'b00000100_00_00_10_00_10;
    localparam logic [17:0] E_MR   = 18'b00100000_00_00_00_00_00;
    localparam logic [17:0] E_MWB  = 18'b00001000_01_00_00_00_00;
    localparam logic [17:0] E_MW   = 18'b00110000_00_00_00_00_00;
    localparam logic [17:0] E_EXX  = 18'b00000100_00_00_00_00_01;
    localparam logic [17:0] E_EXS  = 18'b00000100_00_00_00_00_11;
    localparam logic [17:0] E_AWB  = 18'b00001000_00_01_00_00_00;
    localparam logic [17:0] E_BR   = 18'b00000110_00_00_00_01_11;
    localparam logic [17:0] E_J    = 18'b10000000_00_00_00_10_00;
    localparam logic [17:0] E_IMMA = 18'b00000100_00_00_10_00_00;
    localparam logic [17:0] E_IS   = 18'b00001001_10_10_00_00_00;
    localparam logic [17:0] E_IV   = 18'b10000001_00_00_00_11_00;

    localparam logic [5:0] T_J  = 6'b000010;
    localparam logic [5:0] T_LW = 6'b100011;
    localparam logic [5:0] T_SW = 6'b101011;

    function automatic logic [17:0] obs();
        return {bus.pc_write, bus.ir_write, bus.lor_d, bus.mem_write, bus.reg_write,
                bus.alu_src_a, bus.is_branch, bus.is_interrupted, bus.mem_to_reg,
                bus.reg_dst, bus.alu_src_b, bus.pc_source, bus.alu_control};
    endfunction

    task automatic do_reset(input logic [5:0] op_i, input logic [5:0] funct_i,
                            input logic [3:0] mask_i, input logic intd_i);
        rst_n        = 1'b0;
        bus.op       = op_i;
        bus.funct    = funct_i;
        bus.irq_mask = mask_i;
        bus.intd     = intd_i;
        bus.irq      = 4'b0000;
        bus.nmi      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] exp [5];
        exp = '{E_F, E_D, E_J, E_PRE, E_F};
        rst_n        = 1'b0;
        bus.op       = T_J;
        bus.funct    = 6'd0;
        bus.irq_mask = 4'b1111;
        bus.intd     = 1'b0;
        bus.irq      = 4'b1111;
        bus.nmi      = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== E_PRE) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), E_PRE); end
        checks++;
        if (bus.int_src !== 3'd0) begin failures++; $display("FAIL reset_int_src got=%0d exp=0", bus.int_src); end
        checks++;
        if (bus.irq_ack !== 4'b0000) begin failures++; $display("FAIL reset_irq_ack got=%b exp=0000", bus.irq_ack); end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL reset_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
        end
        checks++;
        if (bus.int_src !== 3'd0) begin failures++; $display("FAIL high_at_release_taken int_src=%0d exp=0", bus.int_src); end
    endtask

    task automatic test_reset_mid_write();
        logic [17:0] exp [4];
        exp = '{E_F, E_D, E_MA, E_MW};
        do_reset(T_SW, 6'd0, 4'b1111, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL sw_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || obs() !== E_PRE) begin
            failures++; $display("FAIL async_reset_mem_write got=%b exp=%b", obs(), E_PRE);
        end
        @(negedge clk);
        checks++;
        if (obs() !== E_PRE) begin failures++; $display("FAIL reset_prefetch got=%b exp=%b", obs(), E_PRE); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== E_F) begin failures++; $display("FAIL reset_then_fetch got=%b exp=%b", obs(), E_F); end
    endtask

    task automatic test_lw();
        logic [17:0] exp [7];
        exp = '{E_F, E_D, E_MA, E_MR, E_MWB, E_PRE, E_F};
        do_reset(T_LW, 6'd0, 4'b1111, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL lw_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
        end
    endtask

    task automatic test_exec_branch_imm();
        logic [17:0] exp [20];
        exp = '{E_F, E_D, E_EXX, E_AWB, E_PRE, E_F, E_D, E_EXS, E_AWB, E_PRE,
                E_F, E_D, E_BR, E_PRE, E_F, E_D, E_IMMA, E_AWB, E_PRE, E_F};
        do_reset(6'b000000, 6'b100110, 4'b1111, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL exec_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
            if (i == 5)  bus.funct = 6'b100010;
            if (i == 10) bus.op = 6'b000100;
            if (i == 14) begin bus.op = 6'b001100; bus.funct = 6'b100100; end
        end
    endtask

    task automatic test_priority();
        logic [17:0] exp [17];
        exp = '{E_F, E_D, E_J, E_PRE, E_IS, E_IV, E_F, E_D, E_J, E_PRE,
                E_IS, E_IV, E_F, E_D, E_J, E_PRE, E_F};
        do_reset(T_J, 6'd0, 4'b1111, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL prio_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
            if (i == 1) bus.irq = 4'b0011;
            if (i == 5) begin
                checks++;
                if (bus.int_src !== 3'd1 || bus.irq_ack !== 4'b0000) begin
                    failures++; $display("FAIL prio_first_src int_src=%0d ack=%b exp=1/0000", bus.int_src, bus.irq_ack);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.irq_ack !== 4'b0001) begin failures++; $display("FAIL prio_first_ack got=%b exp=0001", bus.irq_ack); end
            end
            if (i == 7) begin
                checks++;
                if (bus.irq_ack !== 4'b0000) begin failures++; $display("FAIL ack_not_pulse got=%b exp=0000", bus.irq_ack); end
            end
            if (i == 11) begin
                checks++;
                if (bus.int_src !== 3'd2) begin failures++; $display("FAIL prio_second_src got=%0d exp=2", bus.int_src); end
            end
            if (i == 12) begin
                checks++;
                if (bus.irq_ack !== 4'b0010) begin failures++; $display("FAIL prio_second_ack got=%b exp=0010", bus.irq_ack); end
            end
        end
    endtask

    task automatic test_mask();
        logic [17:0] exp [15];
        exp = '{E_F, E_D, E_J, E_PRE, E_F, E_D, E_J, E_PRE, E_F, E_D, E_J, E_PRE, E_IS, E_IV, E_F};
        do_reset(T_J, 6'd0, 4'b1011, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL mask_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
            if (i == 1) bus.irq = 4'b0100;
            if (i == 9) bus.irq_mask = 4'b1111;
            if (i == 13) begin
                checks++;
                if (bus.int_src !== 3'd3) begin failures++; $display("FAIL mask_src got=%0d exp=3", bus.int_src); end
            end
            if (i == 14) begin
                checks++;
                if (bus.irq_ack !== 4'b0100) begin failures++; $display("FAIL mask_ack got=%b exp=0100", bus.irq_ack); end
            end
        end
    endtask

    task automatic test_nmi_intd();
        logic [17:0] exp [21];
        exp = '{E_F, E_D, E_J, E_PRE, E_IS, E_IV, E_F, E_D, E_J, E_PRE, E_F,
                E_D, E_J, E_PRE, E_IS, E_IV, E_F, E_D, E_J, E_PRE, E_F};
        do_reset(T_J, 6'd0, 4'b1111, 1'b1);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL nmi_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
            if (i == 1) begin bus.nmi = 1'b1; bus.irq = 4'b0001; end
            if (i == 11) bus.intd = 1'b0;
            if (i == 5) begin
                checks++;
                if (bus.int_src !== 3'd0) begin failures++; $display("FAIL nmi_src got=%0d exp=0", bus.int_src); end
            end
            if (i == 6) begin
                checks++;
                if (bus.irq_ack !== 4'b0000) begin failures++; $display("FAIL nmi_ack got=%b exp=0000", bus.irq_ack); end
            end
            if (i == 15) begin
                checks++;
                if (bus.int_src !== 3'd1) begin failures++; $display("FAIL intd_release_src got=%0d exp=1", bus.int_src); end
            end
            if (i == 16) begin
                checks++;
                if (bus.irq_ack !== 4'b0001) begin failures++; $display("FAIL intd_release_ack got=%b exp=0001", bus.irq_ack); end
            end
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp [11];
        exp = '{E_F, E_D, E_PRE, E_IS, E_IV, E_F, E_D, E_PRE, E_IS, E_IV, E_F};
        do_reset(6'b111111, 6'd0, 4'b1111, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[i-1]) begin
                failures++; $display("FAIL illegal_walk cyc=%0d got=%b exp=%b", i, obs(), exp[i-1]);
            end
            if (i == 3) begin
                checks++;
                if (bus.int_src !== 3'd0) begin failures++; $display("FAIL illegal_early_src got=%0d exp=0", bus.int_src); end
            end
            if (i == 4 || i == 9) begin
                checks++;
                if (bus.int_src !== 3'd5) begin failures++; $display("FAIL illegal_src cyc=%0d got=%0d exp=5", i, bus.int_src); end
            end
            if (i == 5 || i == 10) begin
                checks++;
                if (bus.irq_ack !== 4'b0000) begin failures++; $display("FAIL illegal_ack cyc=%0d got=%b exp=0000", i, bus.irq_ack); end
            end
            if (i == 6) begin bus.op = 6'b000000; bus.funct = 6'b100111; end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_lw();
        test_exec_branch_imm();
        test_priority();
        test_mask();
        test_nmi_intd();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
